// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit buffer.
//   tx_state_e          : shifter FSM state encoding
//   DATA_BITS/FRAME_BITS: 8N1 frame geometry (1 start + 8 data + 1 stop)
//   DEFAULT_CLK_PER_BIT : 100 MHz system clock at 115200 baud
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_e;

   localparam int DATA_BITS           = 8;
   localparam int FRAME_BITS          = 10;
   localparam int DEFAULT_CLK_PER_BIT = 868;

endpackage

// File: rtl/uart_tx_buffer_fifo.sv
// Synchronous FIFO used to queue bytes ahead of the UART shifter.
// Ports:
//   clk, rst  : single clock, synchronous active-high reset
//   push_i    : write strobe, accepted only while the FIFO is not full
//   din_i     : write data
//   pop_i     : read strobe, removes the head when not empty
//   dout_o    : head of the FIFO (combinational read)
//   full_o    : level == DEPTH
//   empty_o   : level == 0
//   level_o   : number of entries held
module sync_fifo #(
   parameter int WIDTH      = 8,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push_i,
   input  logic [WIDTH-1:0]      din_i,
   input  logic                  pop_i,
   output logic [WIDTH-1:0]      dout_o,
   output logic                  full_o,
   output logic                  empty_o,
   output logic [DEPTH_LOG2:0]   level_o
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [WIDTH-1:0]      mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q;
   logic [DEPTH_LOG2-1:0] rd_ptr_q;
   logic [DEPTH_LOG2:0]   level_q;
   logic                  push_ok;
   logic                  pop_ok;

   assign full_o  = (level_q == (DEPTH_LOG2+1)'(DEPTH));
   assign empty_o = (level_q == '0);
   assign level_o = level_q;
   assign dout_o  = mem_q[rd_ptr_q];

   // Fullness is judged on the pre-edge level, so a pop in the same cycle
   // never makes room for a push.
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
         case ({push_ok, pop_ok})
            2'b10:   level_q <= level_q + (DEPTH_LOG2+1)'(1);
            2'b01:   level_q <= level_q - (DEPTH_LOG2+1)'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   // Storage carries no reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= din_i;
   end

endmodule

// File: rtl/uart_tx_buffer.sv
// UART transmit buffer: queues one-cycle byte strobes from the core and
// serialises them as 8N1 frames, LSB first, on a registered txd line.
// Ports:
//   clk, rst   : single clock, synchronous active-high reset
//   tx_ready   : one-cycle write strobe from the core
//   sdata      : byte sampled when tx_ready=1
//   txd        : serial output, idle high
//   busy       : FIFO non-empty or a frame in progress
//   fifo_full  : queue holds DEPTH bytes
//   fifo_empty : queue holds no bytes
//   overflow   : sticky, a strobe arrived while the queue was full
//   level      : bytes queued, excluding the one being shifted
import uart_pkg::*;

module uart_tx_buffer #(
   parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT,
   parameter int DEPTH_LOG2  = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                tx_ready,
   input  logic [7:0]          sdata,
   output logic                txd,
   output logic                busy,
   output logic                fifo_full,
   output logic                fifo_empty,
   output logic                overflow,
   output logic [DEPTH_LOG2:0] level
);

   localparam int BAUD_W = $clog2(CLK_PER_BIT);

   tx_state_e         state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        shift_q, shift_d;
   logic              txd_q, txd_d;
   logic              overflow_q;
   logic              baud_end;
   logic              fifo_pop;
   logic [7:0]        fifo_dout;

   sync_fifo #(
      .WIDTH      (8),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (tx_ready),
      .din_i   (sdata),
      .pop_i   (fifo_pop),
      .dout_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (level)
   );

   assign baud_end = (baud_q == BAUD_W'(CLK_PER_BIT - 1));

   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      fifo_pop = 1'b0;
      case (state_q)
         IDLE: begin
            baud_d = '0;
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               shift_d  = fifo_dout;
               state_d  = START;
            end
         end
         START: begin
            if (baud_end) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = DATA;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         DATA: begin
            if (baud_end) begin
               baud_d  = '0;
               shift_d = {1'b0, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'(DATA_BITS - 1)) state_d = STOP;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         STOP: begin
            if (baud_end) begin
               baud_d = '0;
               // Chain straight into the next start bit when more data waits.
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  shift_d  = fifo_dout;
                  state_d  = START;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // txd is decoded from the next state so the line moves on the same edge
   // as the state/bit change and never glitches.
   always_comb begin
      case (state_d)
         START:   txd_d = 1'b0;
         DATA:    txd_d = shift_d[0];
         default: txd_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         baud_q     <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         txd_q      <= 1'b1;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         txd_q      <= txd_d;
         overflow_q <= overflow_q | (tx_ready & fifo_full);
      end
   end

   assign txd      = txd_q;
   assign overflow = overflow_q;
   assign busy     = (state_q != IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_uart_tx_buffer.sv
module tb_uart_tx_buffer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // dut_a: fast baud, deep FIFO
   logic       a_rst, a_txr;
   logic [7:0] a_sd;
   logic       a_txd, a_busy, a_full, a_empty, a_ovf;
   logic [4:0] a_lvl;

   // dut_b: slower baud, 4-entry FIFO
   logic       b_rst, b_txr;
   logic [7:0] b_sd;
   logic       b_txd, b_busy, b_full, b_empty, b_ovf;
   logic [2:0] b_lvl;

   uart_tx_buffer #(.CLK_PER_BIT(4), .DEPTH_LOG2(4)) dut_a (
      .clk(clk), .rst(a_rst), .tx_ready(a_txr), .sdata(a_sd),
      .txd(a_txd), .busy(a_busy), .fifo_full(a_full), .fifo_empty(a_empty),
      .overflow(a_ovf), .level(a_lvl)
   );

   uart_tx_buffer #(.CLK_PER_BIT(16), .DEPTH_LOG2(2)) dut_b (
      .clk(clk), .rst(b_rst), .tx_ready(b_txr), .sdata(b_sd),
      .txd(b_txd), .busy(b_busy), .fifo_full(b_full), .fifo_empty(b_empty),
      .overflow(b_ovf), .level(b_lvl)
   );

   logic       tx_log [1024];
   logic       bz_log [1024];
   logic [4:0] lv_log [1024];

   function automatic logic frame_bit(input logic [7:0] b, input int idx);
      if (idx == 0) return 1'b0;
      else if (idx <= 8) return b[idx-1];
      else return 1'b1;
   endfunction

   task automatic record_a(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         tx_log[k] = a_txd; bz_log[k] = a_busy; lv_log[k] = a_lvl;
      end
   endtask

   task automatic record_b(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         tx_log[k] = b_txd; bz_log[k] = b_busy; lv_log[k] = {2'b00, b_lvl};
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      a_rst = 1'b1; b_rst = 1'b1; a_txr = 1'b0; b_txr = 1'b0;
      repeat (2) @(negedge clk);
      tests++;
      if ({a_txd, a_busy, a_full, a_empty, a_ovf, a_lvl} !== {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0}) begin
         fails++;
         $display("FAIL reset_a {txd,busy,full,empty,ovf,level}: got %b want %b",
                  {a_txd, a_busy, a_full, a_empty, a_ovf, a_lvl}, {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0});
      end
      tests++;
      if ({b_txd, b_busy, b_full, b_empty, b_ovf, b_lvl} !== {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0}) begin
         fails++;
         $display("FAIL reset_b {txd,busy,full,empty,ovf,level}: got %b want %b",
                  {b_txd, b_busy, b_full, b_empty, b_ovf, b_lvl}, {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0});
      end
      a_rst = 1'b0; b_rst = 1'b0;
   endtask

   task automatic test_single();
      @(negedge clk);
      a_txr = 1'b1; a_sd = 8'h55;
      @(negedge clk);
      a_txr = 1'b0;
      tests++;
      if ({a_txd, a_busy, a_empty, a_lvl} !== {1'b1, 1'b1, 1'b0, 5'd1}) begin
         fails++;
         $display("FAIL single_after_strobe {txd,busy,empty,level}: got %b want %b",
                  {a_txd, a_busy, a_empty, a_lvl}, {1'b1, 1'b1, 1'b0, 5'd1});
      end
      record_a(40);
      for (int k = 0; k < 40; k++) begin
         tests++;
         if (tx_log[k] !== frame_bit(8'h55, k / 4)) begin
            fails++;
            $display("FAIL single_txd[%0d]: got %b want %b", k, tx_log[k], frame_bit(8'h55, k / 4));
         end
         tests++;
         if (bz_log[k] !== 1'b1) begin
            fails++;
            $display("FAIL single_busy[%0d]: got %b want 1", k, bz_log[k]);
         end
      end
      @(negedge clk);
      tests++;
      if ({a_txd, a_busy, a_lvl} !== {1'b1, 1'b0, 5'd0}) begin
         fails++;
         $display("FAIL single_end {txd,busy,level}: got %b want %b", {a_txd, a_busy, a_lvl}, {1'b1, 1'b0, 5'd0});
      end
   endtask

   task automatic test_burst();
      logic [7:0] bb [3];
      logic [4:0] maxl;
      logic       exp;
      bb[0] = 8'hA1; bb[1] = 8'h02; bb[2] = 8'hFF;
      @(negedge clk);
      a_txr = 1'b1; a_sd = bb[0];
      @(negedge clk);
      tests++;
      if (a_lvl !== 5'd1) begin fails++; $display("FAIL burst_level_e0: got %0d want 1", a_lvl); end
      a_sd = bb[1];
      @(negedge clk);
      tests++;
      if ({a_lvl, a_txd} !== {5'd1, 1'b0}) begin
         fails++; $display("FAIL burst_e1 {level,txd}: got %b want %b", {a_lvl, a_txd}, {5'd1, 1'b0});
      end
      a_sd = bb[2];
      @(negedge clk);
      a_txr = 1'b0;
      tests++;
      if ({a_lvl, a_txd} !== {5'd2, 1'b0}) begin
         fails++; $display("FAIL burst_e2 {level,txd}: got %b want %b", {a_lvl, a_txd}, {5'd2, 1'b0});
      end
      record_a(118);
      maxl = 5'd0;
      for (int j = 0; j < 118; j++) begin
         int k;
         k = j + 2;
         exp = frame_bit(bb[k / 40], (k / 4) % 10);
         if (lv_log[j] > maxl) maxl = lv_log[j];
         tests++;
         if (tx_log[j] !== exp) begin
            fails++; $display("FAIL burst_txd[%0d]: got %b want %b", k, tx_log[j], exp);
         end
         tests++;
         if (bz_log[j] !== 1'b1) begin
            fails++; $display("FAIL burst_busy[%0d]: got %b want 1", k, bz_log[j]);
         end
      end
      tests++;
      if (maxl !== 5'd2) begin fails++; $display("FAIL burst_peak_level: got %0d want 2", maxl); end
      @(negedge clk);
      tests++;
      if ({a_txd, a_busy, a_lvl, a_ovf} !== {1'b1, 1'b0, 5'd0, 1'b0}) begin
         fails++;
         $display("FAIL burst_end {txd,busy,level,ovf}: got %b want %b",
                  {a_txd, a_busy, a_lvl, a_ovf}, {1'b1, 1'b0, 5'd0, 1'b0});
      end
   endtask

   task automatic test_reset_midframe();
      int bad;
      @(negedge clk);
      a_txr = 1'b1; a_sd = 8'h3C;
      @(negedge clk);
      a_sd = 8'h11;
      @(negedge clk);
      a_sd = 8'h22;
      @(negedge clk);
      a_txr = 1'b0;
      repeat (8) @(negedge clk);
      tests++;
      if (a_txd !== 1'b0) begin fails++; $display("FAIL midframe_bit1: got %b want 0", a_txd); end
      repeat (8) @(negedge clk);
      tests++;
      if ({a_txd, a_lvl, a_busy} !== {1'b1, 5'd2, 1'b1}) begin
         fails++;
         $display("FAIL midframe_bit3 {txd,level,busy}: got %b want %b", {a_txd, a_lvl, a_busy}, {1'b1, 5'd2, 1'b1});
      end
      a_rst = 1'b1;
      @(negedge clk);
      tests++;
      if ({a_txd, a_lvl, a_busy, a_ovf, a_empty} !== {1'b1, 5'd0, 1'b0, 1'b0, 1'b1}) begin
         fails++;
         $display("FAIL midframe_reset {txd,level,busy,ovf,empty}: got %b want %b",
                  {a_txd, a_lvl, a_busy, a_ovf, a_empty}, {1'b1, 5'd0, 1'b0, 1'b0, 1'b1});
      end
      a_rst = 1'b0;
      record_a(100);
      bad = 0;
      for (int k = 0; k < 100; k++) if (tx_log[k] !== 1'b1 || bz_log[k] !== 1'b0) bad++;
      tests++;
      if (bad !== 0) begin fails++; $display("FAIL midframe_quiet: got %0d active cycles want 0", bad); end
   endtask

   task automatic test_overflow();
      logic exp_tx, exp_bz;
      @(negedge clk);
      b_txr = 1'b1; b_sd = 8'h10;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         if (i == 5) begin
            tests++;
            if ({b_full, b_lvl, b_ovf} !== {1'b1, 3'd4, 1'b0}) begin
               fails++;
               $display("FAIL ovf_fill {full,level,ovf}: got %b want %b", {b_full, b_lvl, b_ovf}, {1'b1, 3'd4, 1'b0});
            end
         end
         b_sd = 8'h10 + 8'(i);
      end
      @(negedge clk);
      b_txr = 1'b0;
      tests++;
      if ({b_ovf, b_lvl, b_full, b_txd} !== {1'b1, 3'd4, 1'b1, 1'b0}) begin
         fails++;
         $display("FAIL ovf_drop {ovf,level,full,txd}: got %b want %b", {b_ovf, b_lvl, b_full, b_txd}, {1'b1, 3'd4, 1'b1, 1'b0});
      end
      record_b(995);
      for (int j = 0; j < 995; j++) begin
         int k;
         k = j + 5;
         exp_tx = (k < 800) ? frame_bit(8'h10 + 8'(k / 160), (k / 16) % 10) : 1'b1;
         exp_bz = (k < 800);
         tests++;
         if (tx_log[j] !== exp_tx) begin
            fails++; $display("FAIL ovf_txd[%0d]: got %b want %b", k, tx_log[j], exp_tx);
         end
         tests++;
         if (bz_log[j] !== exp_bz) begin
            fails++; $display("FAIL ovf_busy[%0d]: got %b want %b", k, bz_log[j], exp_bz);
         end
      end
      tests++;
      if (b_ovf !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b want 1", b_ovf); end
   endtask

   task automatic test_full_pop();
      @(negedge clk);
      b_rst = 1'b1;
      @(negedge clk);
      b_rst = 1'b0;
      tests++;
      if (b_ovf !== 1'b0) begin fails++; $display("FAIL fullpop_ovf_cleared: got %b want 0", b_ovf); end
      b_txr = 1'b1; b_sd = 8'h20;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         b_sd = 8'h20 + 8'(i);
      end
      @(negedge clk);
      b_txr = 1'b0;
      repeat (156) @(negedge clk);
      tests++;
      if ({b_full, b_lvl, b_ovf, b_txd} !== {1'b1, 3'd4, 1'b0, 1'b1}) begin
         fails++;
         $display("FAIL fullpop_before {full,level,ovf,txd}: got %b want %b", {b_full, b_lvl, b_ovf, b_txd}, {1'b1, 3'd4, 1'b0, 1'b1});
      end
      b_txr = 1'b1; b_sd = 8'h25;
      @(negedge clk);
      b_txr = 1'b0;
      tests++;
      if ({b_lvl, b_ovf, b_full, b_txd} !== {3'd3, 1'b1, 1'b0, 1'b0}) begin
         fails++;
         $display("FAIL fullpop_after {level,ovf,full,txd}: got %b want %b", {b_lvl, b_ovf, b_full, b_txd}, {3'd3, 1'b1, 1'b0, 1'b0});
      end
   endtask

   task automatic test_wraparound();
      logic [7:0] rx [11];
      int nrx, stop_err, w;
      logic abort;
      nrx = 0; stop_err = 0; abort = 1'b0;
      @(negedge clk);
      b_rst = 1'b1;
      @(negedge clk);
      b_rst = 1'b0;
      fork
         begin
            for (int i = 0; i < 11; i++) begin
               b_txr = 1'b1; b_sd = 8'(i);
               @(negedge clk);
               b_txr = 1'b0;
               repeat ((i % 3 == 2) ? 500 : 1) @(negedge clk);
            end
         end
         begin
            for (int n = 0; n < 11; n++) begin
               if (!abort) begin
                  w = 0;
                  while (b_txd !== 1'b0 && w < 3000) begin @(negedge clk); w++; end
                  if (w >= 3000) abort = 1'b1;
                  else begin
                     repeat (8) @(negedge clk);
                     if (b_txd !== 1'b0) stop_err++;
                     for (int b = 0; b < 8; b++) begin
                        repeat (16) @(negedge clk);
                        rx[n][b] = b_txd;
                     end
                     repeat (16) @(negedge clk);
                     if (b_txd !== 1'b1) stop_err++;
                     nrx++;
                  end
               end
            end
         end
      join
      tests++;
      if (nrx !== 11) begin fails++; $display("FAIL wrap_count: got %0d frames want 11", nrx); end
      for (int n = 0; n < nrx; n++) begin
         tests++;
         if (rx[n] !== 8'(n)) begin fails++; $display("FAIL wrap_byte[%0d]: got %h want %h", n, rx[n], 8'(n)); end
      end
      tests++;
      if (stop_err !== 0) begin fails++; $display("FAIL wrap_framing: got %0d bad start/stop want 0", stop_err); end
      repeat (20) @(negedge clk);
      tests++;
      if ({b_lvl, b_ovf, b_busy, b_txd} !== {3'd0, 1'b0, 1'b0, 1'b1}) begin
         fails++;
         $display("FAIL wrap_end {level,ovf,busy,txd}: got %b want %b", {b_lvl, b_ovf, b_busy, b_txd}, {3'd0, 1'b0, 1'b0, 1'b1});
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, tests=%0d", tests);
      $fatal(1, "watchdog expired");
   end

   initial begin
      a_rst = 1'b1; b_rst = 1'b1;
      a_txr = 1'b0; b_txr = 1'b0;
      a_sd  = 8'h00; b_sd = 8'h00;
      test_reset();
      test_single();
      test_burst();
      test_reset_midframe();
      test_overflow();
      test_full_pop();
      test_wraparound();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
